// File: rtl/si5340_cfg_seq.sv
// Si5340 configuration sequencer: streams ROM register words to an I2C byte master,
// inserting page-select writes and a settle pause after the preamble.
module si5340_cfg_seq #(
   parameter int unsigned WORD_NUMBER   = 326,
   parameter logic [6:0]  DEV_ADDR      = 7'h74,
   parameter int unsigned PREAMBLE_LAST = 2,
   parameter int unsigned DELAY_CYCLES  = 37_500_000
) (
   input  logic                           clk_i,
   input  logic                           arst_i,
   input  logic                           start_i,
   output logic [$clog2(WORD_NUMBER)-1:0] rom_addr_o,
   input  logic [23:0]                    rom_data_i,
   output logic                           wr_valid_o,
   input  logic                           wr_ready_i,
   output logic [7:0]                     wr_data_o,
   output logic                           wr_start_o,
   output logic                           wr_stop_o,
   input  logic                           ack_valid_i,
   input  logic                           ack_nack_i,
   output logic                           busy_o,
   output logic                           done_o,
   output logic                           error_o
);

   localparam int unsigned AW = $clog2(WORD_NUMBER);
   localparam logic [AW-1:0] IdxPreamble = AW'(PREAMBLE_LAST);
   localparam logic [AW-1:0] IdxLast     = AW'(WORD_NUMBER - 1);

   typedef enum logic [3:0] {
      StIdle, StFetch, StRomWait, StPageChk, StSend, StWaitAck, StDelay, StDone, StError
   } state_e;

   state_e        state_q;
   logic [AW-1:0] idx_q;
   logic          page_valid_q;
   logic [7:0]    page_q;
   logic [23:0]   word_q;
   logic [1:0]    byte_q;
   logic          page_txn_q;
   logic [31:0]   cnt_q;
   logic          page_miss;

   assign page_miss = !page_valid_q || (rom_data_i[23:16] != page_q);

   // Bytes 1/2 of a transaction: page select is reg 0x01 with the address high byte as data.
   function automatic logic [7:0] txn_byte(input logic [1:0] sel, input logic page_txn,
                                           input logic [23:0] word);
      case (sel)
         2'd0:    txn_byte = {DEV_ADDR, 1'b0};
         2'd1:    txn_byte = page_txn ? 8'h01 : word[15:8];
         default: txn_byte = page_txn ? word[23:16] : word[7:0];
      endcase
   endfunction

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         state_q      <= StIdle;
         idx_q        <= '0;
         page_valid_q <= 1'b0;
         page_q       <= '0;
         word_q       <= '0;
         byte_q       <= '0;
         page_txn_q   <= 1'b0;
         cnt_q        <= '0;
         rom_addr_o   <= '0;
         wr_valid_o   <= 1'b0;
         wr_data_o    <= '0;
         wr_start_o   <= 1'b0;
         wr_stop_o    <= 1'b0;
         busy_o       <= 1'b0;
         done_o       <= 1'b0;
         error_o      <= 1'b0;
      end else begin
         case (state_q)
            StIdle, StDone, StError: begin
               if (start_i) begin
                  state_q      <= StFetch;
                  idx_q        <= '0;
                  page_valid_q <= 1'b0;
                  done_o       <= 1'b0;
                  error_o      <= 1'b0;
                  busy_o       <= 1'b1;
               end
            end
            StFetch: begin
               rom_addr_o <= idx_q;
               state_q    <= StRomWait;
            end
            StRomWait: state_q <= StPageChk;
            StPageChk: begin
               word_q     <= rom_data_i;
               page_txn_q <= page_miss;
               byte_q     <= 2'd0;
               wr_valid_o <= 1'b1;
               wr_data_o  <= {DEV_ADDR, 1'b0};
               wr_start_o <= 1'b1;
               wr_stop_o  <= 1'b0;
               state_q    <= StSend;
            end
            StSend: begin
               if (wr_ready_i) begin
                  wr_valid_o <= 1'b0;
                  wr_start_o <= 1'b0;
                  wr_stop_o  <= 1'b0;
                  state_q    <= StWaitAck;
               end
            end
            StWaitAck: begin
               if (ack_valid_i) begin
                  if (ack_nack_i) begin
                     state_q <= StError;
                     error_o <= 1'b1;
                     busy_o  <= 1'b0;
                  end else if (byte_q != 2'd2) begin
                     byte_q     <= byte_q + 2'd1;
                     wr_valid_o <= 1'b1;
                     wr_data_o  <= txn_byte(byte_q + 2'd1, page_txn_q, word_q);
                     wr_stop_o  <= (byte_q == 2'd1);
                     state_q    <= StSend;
                  end else if (page_txn_q) begin
                     // Page is now selected; follow with the register write itself.
                     page_q       <= word_q[23:16];
                     page_valid_q <= 1'b1;
                     page_txn_q   <= 1'b0;
                     byte_q       <= 2'd0;
                     wr_valid_o   <= 1'b1;
                     wr_data_o    <= {DEV_ADDR, 1'b0};
                     wr_start_o   <= 1'b1;
                     state_q      <= StSend;
                  end else if (idx_q == IdxPreamble) begin
                     cnt_q   <= '0;
                     state_q <= StDelay;
                  end else if (idx_q == IdxLast) begin
                     state_q <= StDone;
                     done_o  <= 1'b1;
                     busy_o  <= 1'b0;
                  end else begin
                     idx_q   <= idx_q + AW'(1);
                     state_q <= StFetch;
                  end
               end
            end
            StDelay: begin
               if (cnt_q + 32'd1 >= DELAY_CYCLES) begin
                  cnt_q <= '0;
                  if (idx_q == IdxLast) begin
                     state_q <= StDone;
                     done_o  <= 1'b1;
                     busy_o  <= 1'b0;
                  end else begin
                     idx_q   <= idx_q + AW'(1);
                     state_q <= StFetch;
                  end
               end else begin
                  cnt_q <= cnt_q + 32'd1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_si5340_cfg_seq.sv
// Randomized bench for si5340_cfg_seq: an I2C slave stub with random ready/ack timing and
// a ROM-driven expected byte stream built independently from the page/transaction rules.
module tb_si5340_cfg_seq;

   localparam int unsigned WN = 4;
   localparam int unsigned PL = 1;
   localparam int unsigned DC = 10;

   logic        clk_i = 1'b0;
   logic        arst_i, start_i, wr_ready_i, ack_valid_i, ack_nack_i;
   logic [1:0]  rom_addr_o;
   logic [23:0] rom_data_i;
   logic        wr_valid_o, wr_start_o, wr_stop_o, busy_o, done_o, error_o;
   logic [7:0]  wr_data_o;

   logic [23:0] rom [WN];

   typedef struct packed {
      logic [7:0] data;
      logic       st;
      logic       sp;
      logic       gap;
   } byte_t;

   byte_t exp_q[$];
   int    checks = 0;
   int    errors = 0;
   int    cyc    = 0;

   si5340_cfg_seq #(
      .WORD_NUMBER  (WN),
      .DEV_ADDR     (7'h74),
      .PREAMBLE_LAST(PL),
      .DELAY_CYCLES (DC)
   ) dut (
      .clk_i      (clk_i),
      .arst_i     (arst_i),
      .start_i    (start_i),
      .rom_addr_o (rom_addr_o),
      .rom_data_i (rom_data_i),
      .wr_valid_o (wr_valid_o),
      .wr_ready_i (wr_ready_i),
      .wr_data_o  (wr_data_o),
      .wr_start_o (wr_start_o),
      .wr_stop_o  (wr_stop_o),
      .ack_valid_i(ack_valid_i),
      .ack_nack_i (ack_nack_i),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .error_o    (error_o)
   );

   always #5 clk_i = ~clk_i;

   // Synchronous ROM: data follows the address by one clock.
   always @(posedge clk_i) rom_data_i <= rom[rom_addr_o];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %0h want %0h (cycle %0d)", tag, got, want, cyc);
      end
   endtask

   task automatic tick();
      @(negedge clk_i);
      cyc++;
   endtask

   task automatic push(input logic [7:0] d, input logic st, input logic sp, input logic gap);
      byte_t b;
      b.data = d;
      b.st   = st;
      b.sp   = sp;
      b.gap  = gap;
      exp_q.push_back(b);
   endtask

   // Expected stream: every word is one write; a page-select write precedes it whenever
   // the address high byte differs from the last selected page (or none is selected yet).
   task automatic build_model();
      bit         pv;
      logic [7:0] pg;
      logic [7:0] a;
      bit         gap;
      exp_q.delete();
      pv = 0;
      pg = '0;
      for (int w = 0; w < int'(WN); w++) begin
         a   = rom[w][23:16];
         gap = (w == int'(PL) + 1);
         if (!pv || a != pg) begin
            push(8'hE8, 1'b1, 1'b0, gap);
            push(8'h01, 1'b0, 1'b0, 1'b0);
            push(a,     1'b0, 1'b1, 1'b0);
            gap = 0;
            pg  = a;
            pv  = 1;
         end
         push(8'hE8,         1'b1, 1'b0, gap);
         push(rom[w][15:8],  1'b0, 1'b0, 1'b0);
         push(rom[w][7:0],   1'b0, 1'b1, 1'b0);
      end
   endtask

   task automatic pulse_start();
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
   endtask

   // Runs one load as the I2C slave. nack_at: byte index to NACK (-1 none);
   // stop_after: return right after ACKing this byte (-1 run to completion).
   task automatic do_load(input int nack_at, input int stop_after, input int force_hold);
      int         n;
      int         hold;
      int         lat;
      int         last_ack;
      bit         seen;
      logic [9:0] snap;
      last_ack = cyc;
      pulse_start();
      check_eq("busy_after_start", {31'd0, busy_o}, 32'd1);
      for (int k = 0; k < exp_q.size(); k++) begin
         n = 0;
         while (!wr_valid_o && n < 300) begin
            tick();
            n++;
         end
         if (!wr_valid_o) begin
            check_eq("valid_timeout", {31'd0, wr_valid_o}, 32'd1);
            return;
         end
         check_eq($sformatf("byte%0d", k), {22'd0, wr_start_o, wr_stop_o, wr_data_o},
                  {22'd0, exp_q[k].st, exp_q[k].sp, exp_q[k].data});
         // Ack edge, DC pause cycles, then FETCH/ROMWAIT/PAGECHK before SEND.
         if (exp_q[k].gap) check_eq("delay_gap", cyc - last_ack, DC + 4);
         hold = (k == 0 && force_hold > 0) ? force_hold : $urandom_range(0, 3);
         snap = {wr_start_o, wr_stop_o, wr_data_o};
         for (int h = 0; h < hold; h++) begin
            ack_valid_i = (h == 0);
            ack_nack_i  = (h == 0);
            start_i     = ($urandom_range(0, 3) == 0);
            tick();
            ack_valid_i = 1'b0;
            ack_nack_i  = 1'b0;
            start_i     = 1'b0;
            check_eq("hold_stable", {21'd0, wr_valid_o, wr_start_o, wr_stop_o, wr_data_o},
                     {21'd0, 1'b1, snap});
         end
         wr_ready_i = 1'b1;
         tick();
         wr_ready_i = 1'b0;
         check_eq("valid_drop", {31'd0, wr_valid_o}, 32'd0);
         lat = $urandom_range(0, 3);
         for (int l = 0; l < lat; l++) begin
            start_i = ($urandom_range(0, 2) == 0);
            tick();
            start_i = 1'b0;
            check_eq("no_byte_before_ack", {31'd0, wr_valid_o}, 32'd0);
         end
         ack_valid_i = 1'b1;
         ack_nack_i  = (k == nack_at);
         last_ack    = cyc;
         tick();
         ack_valid_i = 1'b0;
         ack_nack_i  = 1'b0;
         if (k == nack_at) begin
            check_eq("nack_status", {29'd0, busy_o, done_o, error_o}, 32'b001);
            seen = 0;
            for (int i = 0; i < 30; i++) begin
               tick();
               if (wr_valid_o) seen = 1;
            end
            check_eq("no_byte_after_nack", {31'd0, seen}, 32'd0);
            return;
         end
         if (k == stop_after) return;
      end
      check_eq("done_status", {29'd0, busy_o, done_o, error_o}, 32'b010);
   endtask

   initial begin
      int nk;
      arst_i      = 1'b1;
      start_i     = 1'b0;
      wr_ready_i  = 1'b0;
      ack_valid_i = 1'b0;
      ack_nack_i  = 1'b0;
      rom[0] = 24'h0B24C0;
      rom[1] = 24'h0B2500;
      rom[2] = 24'h0B4E1A;
      rom[3] = 24'h0C0B05;
      repeat (3) tick();
      check_eq("reset_outputs", {16'd0, rom_addr_o, wr_valid_o, wr_start_o, wr_stop_o,
               wr_data_o, busy_o, done_o, error_o}, 32'd0);
      arst_i = 1'b0;
      repeat (5) tick();
      check_eq("idle_after_reset", {29'd0, busy_o, done_o, wr_valid_o}, 32'd0);

      build_model();
      do_load(-1, -1, 5);

      do_load(1, -1, 0);
      do_load(-1, -1, 0);

      // Abort inside the post-preamble pause (last byte of word PL is index 8).
      do_load(-1, 8, 0);
      repeat (3) tick();
      check_eq("in_delay", {30'd0, busy_o, wr_valid_o}, 32'b10);
      arst_i = 1'b1;
      #1;
      check_eq("async_reset", {16'd0, rom_addr_o, wr_valid_o, wr_start_o, wr_stop_o,
               wr_data_o, busy_o, done_o, error_o}, 32'd0);
      tick();
      arst_i = 1'b0;
      repeat (4) tick();
      check_eq("idle_after_abort", {29'd0, busy_o, done_o, wr_valid_o}, 32'd0);
      do_load(-1, -1, 0);

      for (int r = 0; r < 8; r++) begin
         for (int w = 0; w < int'(WN); w++)
            rom[w] = {8'h0B + 8'($urandom_range(0, 2)), 8'($urandom), 8'($urandom)};
         build_model();
         nk = ($urandom_range(0, 2) == 0) ? $urandom_range(0, exp_q.size() - 1) : -1;
         do_load(nk, -1, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/si5340_cfg_seq.md
SI5340_CFG_SEQ -- requirements
Module: si5340_cfg_seq

Interface
REQ-001 The block SHALL have parameter WORD_NUMBER, default 326, meaning the number of 24-bit config words in the ROM.
REQ-002 The block SHALL have parameter DEV_ADDR, default 7'h74, meaning the 7-bit I2C device address.
REQ-003 The block SHALL have parameter PREAMBLE_LAST, default 2, meaning the index of the last preamble word.
REQ-004 The block SHALL have parameter DELAY_CYCLES, default 37_500_000, meaning the post-preamble pause in clocks (300 ms at 125 MHz).
REQ-005 The block SHALL have the port clk_i, input, 1 bit: the single clock.
REQ-006 The block SHALL have the port arst_i, input, 1 bit: the reset; asynchronous, active-high.
REQ-007 The block SHALL have the port start_i, input, 1 bit: a one-cycle pulse that starts a load.
REQ-008 The block SHALL have the port rom_addr_o, output, $clog2(WORD_NUMBER) bits: the word index.
REQ-009 The block SHALL have the port rom_data_i, input, 24 bits: the ROM word, where [23:8] is the register address and [7:0] is the data; it is valid 1 cycle after rom_addr_o.
REQ-010 The block SHALL have the port wr_valid_o, input wr_ready_i, output wr_data_o[7:0], output wr_start_o and output wr_stop_o forming the byte command channel to the I2C master.
REQ-011 The block SHALL have the port ack_valid_i, input, 1 bit: a pulse indicating that the I2C master has finished one byte.
REQ-012 The block SHALL have the port ack_nack_i, input, 1 bit: qualified by ack_valid_i; 1 means NACK.
REQ-013 The block SHALL have the ports busy_o, done_o and error_o, each output, 1 bit: status.

Function
REQ-014 States SHALL be IDLE, FETCH, ROMWAIT, PAGECHK, SEND, WAITACK, DELAY, DONE, ERROR.
REQ-015 IDLE, DONE and ERROR SHALL go to FETCH on start_i, clearing word index, done_o, error_o and page_valid; start_i in any other state SHALL be ignored.
REQ-016 FETCH SHALL drive rom_addr_o, ROMWAIT SHALL wait 1 cycle, and PAGECHK SHALL latch rom_data_i.
REQ-017 PAGECHK: if page_valid=0 or addr[15:8] differs from the current page, the block SHALL queue a page transaction (reg 8'h01, data addr[15:8]) before the register transaction; otherwise it SHALL queue the register transaction only.
REQ-018 Each transaction SHALL be 3 bytes: {DEV_ADDR,1'b0} with wr_start_o=1, then the register byte, then the data byte with wr_stop_o=1; wr_start_o and wr_stop_o SHALL be 0 otherwise.
REQ-019 SEND SHALL hold wr_valid_o=1 and wr_data_o/wr_start_o/wr_stop_o stable until the cycle where wr_ready_i=1, then go to WAITACK with wr_valid_o=0 on the next cycle.
REQ-020 The block SHALL issue no further byte until ack_valid_i; the next byte SHALL be presented no earlier than the cycle after ack_valid_i.
REQ-021 ack_valid_i with ack_nack_i=1 SHALL go to ERROR, setting error_o=1 and busy_o=0; no further bytes SHALL be issued.
REQ-022 After the page data byte ACKs, the block SHALL set the current page to addr[15:8] and page_valid=1.
REQ-023 After the register data byte ACKs: if index==PREAMBLE_LAST the block SHALL go to DELAY; else if index==WORD_NUMBER-1 it SHALL go to DONE; else it SHALL increment the index and go to FETCH.
REQ-024 DELAY SHALL count exactly DELAY_CYCLES clocks, then increment the index and go to FETCH (or to DONE if PREAMBLE_LAST==WORD_NUMBER-1).
REQ-025 DONE SHALL set done_o=1 until the next start; busy_o SHALL be 1 in every state except IDLE, DONE and ERROR.
REQ-026 ack_valid_i outside WAITACK SHALL be ignored.

Reset
REQ-027 arst_i=1 SHALL immediately force IDLE, index 0, page_valid 0, counters 0, rom_addr_o 0, wr_valid_o 0, wr_start_o 0, wr_stop_o 0, wr_data_o 0, busy_o 0, done_o 0, error_o 0, including mid-transaction or mid-DELAY.
REQ-028 After reset deasserts, the block SHALL remain in IDLE until start_i.

Verification (WORD_NUMBER=4, PREAMBLE_LAST=1, DELAY_CYCLES=10, ROM = 0B24C0, 0B2500, 0B4E1A, 0C0B05)
REQ-029 start_i with a slave that always ACKs SHALL produce the byte stream E8,01,0B | E8,24,C0 | E8,25,00 | E8,4E,1A | E8,01,0C | E8,0B,05 followed by done_o=1.
REQ-030 Between the ACK of the 25,00 data byte and the next wr_valid_o, the gap SHALL be at least 10 cycles.
REQ-031 With wr_ready_i held low 5 cycles, wr_valid_o/wr_data_o SHALL stay stable for all 6 cycles and exactly one byte SHALL be accepted.
REQ-032 A NACK on the 2nd byte SHALL give error_o=1, busy_o=0 and no further wr_valid_o; a subsequent start_i SHALL restart from E8,01,0B.
REQ-033 arst_i pulsed during DELAY SHALL return all outputs to 0; a subsequent start_i SHALL replay from word 0 with a page write.
REQ-034 A start_i pulse while busy_o=1 SHALL leave the byte stream unchanged.
